// File: rtl/lane_fifo_arbiter.sv
// Two-lane input buffer with a round-robin arbiter feeding a 2:1 valid-bit mux.
// Each lane owns a small circular FIFO. At most one lane is popped per cycle.
// The popped word, per-lane valid bits and the mux selector are all registered.
module lane_fifo_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push0,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic                  push1,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic                  pause,
    output logic                  full0,
    output logic                  full1,
    output logic                  empty0,
    output logic                  empty1,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic                  valid_bit0,
    output logic                  valid_bit1,
    output logic                  selector,
    output logic                  error
);

    // IDLE: nothing popped last cycle; SERVEx: lane x popped last cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } arb_state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = '0;
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    // Lane FIFO storage and bookkeeping, indexed by lane.
    logic [DATA_WIDTH-1:0] r_mem [2][DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr [2];
    logic [ADDR_WIDTH-1:0] r_rd_ptr [2];
    logic [ADDR_WIDTH:0]   r_count  [2];
    logic                  r_error;

    // Arbiter state and registered outputs.
    arb_state_t            r_state;
    logic                  r_last_sel;
    logic [DATA_WIDTH-1:0] r_data_out0;
    logic [DATA_WIDTH-1:0] r_data_out1;
    logic                  r_valid0;
    logic                  r_valid1;
    logic                  r_selector;

    logic                  w_push    [2];
    logic [DATA_WIDTH-1:0] w_din     [2];
    logic [DATA_WIDTH-1:0] w_rd_data [2];
    logic                  w_full    [2];
    logic                  w_empty   [2];
    logic                  w_pop     [2];
    logic                  w_wr_en   [2];
    logic                  w_any_pop;
    logic                  w_pop_lane;
    logic                  w_last_sel;
    logic                  w_overflow;

    assign w_push[0] = push0;
    assign w_push[1] = push1;
    assign w_din[0]  = data_in0;
    assign w_din[1]  = data_in1;

    // Per-lane status and head-of-queue read, all from pre-edge state.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_full[i]    = (r_count[i] == FULL_COUNT);
            w_empty[i]   = (r_count[i] == CNT_ZERO);
            w_rd_data[i] = r_mem[i][r_rd_ptr[i]];
        end
    end

    // Effective last-served lane: SERVEx states imply it, IDLE keeps the stored copy.
    always_comb begin
        w_last_sel = r_last_sel;
        case (r_state)
            SERVE0:  w_last_sel = 1'b0;
            SERVE1:  w_last_sel = 1'b1;
            default: w_last_sel = r_last_sel;
        endcase
    end

    // Round-robin pick: alternate when both lanes hold data, else serve whichever does.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_any_pop  = 1'b0;
        w_pop_lane = 1'b0;
        if (!pause) begin
            if (!w_empty[0] && !w_empty[1]) begin
                w_any_pop  = 1'b1;
                w_pop_lane = ~w_last_sel;
            end else if (!w_empty[0]) begin
                w_any_pop  = 1'b1;
                w_pop_lane = 1'b0;
            end else if (!w_empty[1]) begin
                w_any_pop  = 1'b1;
                w_pop_lane = 1'b1;
            end
        end
        w_pop[0] = w_any_pop && !w_pop_lane;
        w_pop[1] = w_any_pop &&  w_pop_lane;
    end

    // A push into a full lane is accepted only when that lane is popped in the same cycle.
    always_comb begin
        w_overflow = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w_wr_en[i] = w_push[i] && (!w_full[i] || w_pop[i]);
            if (w_push[i] && w_full[i] && !w_pop[i]) begin
                w_overflow = 1'b1;
            end
        end
    end

    // FIFO storage write; no reset so stale words may survive a reset.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately left out of reset; the pointers and counts define validity.
        for (int i = 0; i < 2; i++) begin
            if (w_wr_en[i]) begin
                r_mem[i][r_wr_ptr[i]] <= w_din[i];
            end
        end
    end

    // Pointer, count and sticky overflow bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_error <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_wr_en[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_ONE;
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_ONE;
                end
                case ({w_wr_en[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_ONE;
                    2'b01:   r_count[i] <= r_count[i] - CNT_ONE;
                    default: r_count[i] <= r_count[i];
                endcase
            end
            if (w_overflow) begin
                r_error <= 1'b1;
            end
        end
    end

    // Arbiter FSM: records the served lane and registers the mux-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last_sel  <= 1'b1;
            r_data_out0 <= '0;
            r_data_out1 <= '0;
            r_valid0    <= 1'b0;
            r_valid1    <= 1'b0;
            r_selector  <= 1'b0;
        end else if (w_any_pop) begin
            r_last_sel <= w_pop_lane;
            r_selector <= w_pop_lane;
            if (w_pop_lane) begin
                r_state     <= SERVE1;
                r_data_out1 <= w_rd_data[1];
                r_valid0    <= 1'b0;
                r_valid1    <= 1'b1;
            end else begin
                r_state     <= SERVE0;
                r_data_out0 <= w_rd_data[0];
                r_valid0    <= 1'b1;
                r_valid1    <= 1'b0;
            end
        end else begin
            r_state    <= IDLE;
            r_last_sel <= w_last_sel;
            r_valid0   <= 1'b0;
            r_valid1   <= 1'b0;
        end
    end

    assign full0      = w_full[0];
    assign full1      = w_full[1];
    assign empty0     = w_empty[0];
    assign empty1     = w_empty[1];
    assign data_out0  = r_data_out0;
    assign data_out1  = r_data_out1;
    assign valid_bit0 = r_valid0;
    assign valid_bit1 = r_valid1;
    assign selector   = r_selector;
    assign error      = r_error;

endmodule
